// File: rtl/ldd_pulse_mon.sv
// ldd_pulse_mon
// Loop-back monitor for the LDD0 driver pad lines. During a measurement
// window it counts WP pulses on the enabled channels, tracks the widest WP
// high time, flags WP/WN shoot-through and compares the final count with
// the commanded count.
//
// Ports
//   clk200     200 MHz sampling clock
//   rst        asynchronous reset, active low
//   mon_wdis   channel enable mask, latched at mon_start
//   mon_plus   expected pulse count, latched at mon_start
//   mon_start  one-cycle window request (honoured in IDLE/DONE)
//   mon_abort  return to IDLE and clear results
//   LDD0_WP    driver positive pad lines (asynchronous)
//   LDD0_WN    driver negative pad lines (asynchronous)
//   mon_rdy    high in IDLE and DONE
//   mon_done   one-cycle pulse on DONE entry
//   mon_cnt    pulses counted in the window
//   mon_wmax   widest WP high time, clk200 cycles
//   mon_seen   channels that produced at least one pulse
//   mon_err    result invalid (count mismatch, shoot-through or timeout)
//   mon_ovl    shoot-through seen
//   mon_tmo    window ended by timeout with no pulse
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no window; waiting for mon_start
// ARM    | window open, no pulse yet; gap timer running
// RUN    | at least one pulse seen; each pulse reloads the gap timer
// DONE   | results frozen until the next mon_start
module ldd_pulse_mon #(
    parameter int TOP0_0  = 3,
    parameter int LDD0_0  = 32,
    parameter int WID_W   = 16,
    parameter int TMO_CYC = 20000
) (
    input  logic              clk200,
    input  logic              rst,
    input  logic [TOP0_0-1:0] mon_wdis,
    input  logic [LDD0_0-1:0] mon_plus,
    input  logic              mon_start,
    input  logic              mon_abort,
    input  logic [TOP0_0-1:0] LDD0_WP,
    input  logic [TOP0_0-1:0] LDD0_WN,
    output logic              mon_rdy,
    output logic              mon_done,
    output logic [LDD0_0-1:0] mon_cnt,
    output logic [WID_W-1:0]  mon_wmax,
    output logic [TOP0_0-1:0] mon_seen,
    output logic              mon_err,
    output logic              mon_ovl,
    output logic              mon_tmo
);

    localparam int               TMR_W    = $clog2(TMO_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TMO_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [TOP0_0-1:0] wp_s1, wp_s2, wp_d;
    logic [TOP0_0-1:0] wn_s1, wn_s2;

    logic [TOP0_0-1:0] mask_q;
    logic [LDD0_0-1:0] exp_q;
    logic [LDD0_0-1:0] cnt_q;
    logic [WID_W-1:0]  wmax_q;
    logic [WID_W-1:0]  wcnt_q;
    logic [TOP0_0-1:0] seen_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              err_q, ovl_q, tmo_q, done_q;

    logic              active;
    logic [TOP0_0-1:0] wp_rise;
    logic              pulse_ev;
    logic              wp_hi, wp_hi_d, wp_fall;
    logic              st_hit;
    logic              tmr_tc;
    logic              start_ok;
    logic              done_entry;

    // Two-flop synchronizers plus one edge-detect stage on WP.
    always_ff @(posedge clk200 or negedge rst) begin
        if (!rst) begin
            wp_s1 <= '0;
            wp_s2 <= '0;
            wp_d  <= '0;
            wn_s1 <= '0;
            wn_s2 <= '0;
        end else begin
            wp_s1 <= LDD0_WP;
            wp_s2 <= wp_s1;
            wp_d  <= wp_s2;
            wn_s1 <= LDD0_WN;
            wn_s2 <= wn_s1;
        end
    end

    assign active   = (state == S_ARM) || (state == S_RUN);
    assign wp_rise  = wp_s2 & ~wp_d & mask_q;
    // Coincident rises on several channels are one pulse.
    assign pulse_ev = active && (|wp_rise);
    // Width is measured on the OR of all enabled channels.
    assign wp_hi    = |(wp_s2 & mask_q);
    assign wp_hi_d  = |(wp_d & mask_q);
    assign wp_fall  = wp_hi_d && !wp_hi;
    assign st_hit   = active && (|(wp_s2 & wn_s2 & mask_q));
    // Terminal count one early so DONE lands exactly TMO_CYC cycles after a load.
    assign tmr_tc   = active && (tmr_q == TMR_ONE);
    assign start_ok = mon_start && !mon_abort &&
                      ((state == S_IDLE) || (state == S_DONE));

    // State register
    always_ff @(posedge clk200 or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (mon_start) state_nxt = S_ARM;
            S_ARM: begin
                if (pulse_ev)    state_nxt = S_RUN;
                else if (tmr_tc) state_nxt = S_DONE;
            end
            // A pulse on the terminal cycle reloads the timer and keeps RUN.
            S_RUN:  if (tmr_tc && !pulse_ev) state_nxt = S_DONE;
            S_DONE: if (mon_start) state_nxt = S_ARM;
            default: state_nxt = S_IDLE;
        endcase
        if (mon_abort) state_nxt = S_IDLE;
    end

    assign done_entry = (state_nxt == S_DONE) && (state != S_DONE);

    // Window datapath
    always_ff @(posedge clk200 or negedge rst) begin
        if (!rst) begin
            mask_q <= '0;
            exp_q  <= '0;
            cnt_q  <= '0;
            wmax_q <= '0;
            wcnt_q <= '0;
            seen_q <= '0;
            tmr_q  <= '0;
            err_q  <= 1'b0;
            ovl_q  <= 1'b0;
            tmo_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_entry;
            if (mon_abort) begin
                cnt_q  <= '0;
                wmax_q <= '0;
                wcnt_q <= '0;
                seen_q <= '0;
                tmr_q  <= '0;
                err_q  <= 1'b0;
                ovl_q  <= 1'b0;
                tmo_q  <= 1'b0;
            end else if (start_ok) begin
                mask_q <= mon_wdis;
                exp_q  <= mon_plus;
                cnt_q  <= '0;
                wmax_q <= '0;
                wcnt_q <= '0;
                seen_q <= '0;
                tmr_q  <= TMR_LOAD;
                err_q  <= 1'b0;
                ovl_q  <= 1'b0;
                tmo_q  <= 1'b0;
            end else if (active) begin
                if (pulse_ev) begin
                    tmr_q <= TMR_LOAD;
                    if (cnt_q != '1) cnt_q <= cnt_q + LDD0_0'(1);
                end else if (tmr_q != '0) begin
                    tmr_q <= tmr_q - TMR_ONE;
                end
                seen_q <= seen_q | wp_rise;
                if (st_hit) ovl_q <= 1'b1;
                if (wp_hi) begin
                    if (wcnt_q != '1) wcnt_q <= wcnt_q + WID_W'(1);
                end else begin
                    wcnt_q <= '0;
                end
                if (wp_fall && (wcnt_q > wmax_q)) wmax_q <= wcnt_q;
                if (done_entry) begin
                    tmo_q <= (state == S_ARM);
                    err_q <= (cnt_q != exp_q) || ovl_q || st_hit || (state == S_ARM);
                end
            end
        end
    end

    // Outputs
    always_comb begin
        mon_rdy  = (state == S_IDLE) || (state == S_DONE);
        mon_done = done_q;
        mon_cnt  = cnt_q;
        mon_wmax = wmax_q;
        mon_seen = seen_q;
        mon_err  = err_q;
        mon_ovl  = ovl_q;
        mon_tmo  = tmo_q;
    end

endmodule
